// File: rtl/tpu_output_collector.sv
// tpu_output_collector: reassembles the 8-byte result stream, requantizes to int8 and queues packed words
module tpu_output_collector #(
  parameter int SHIFT = 0,
  parameter int RELU  = 0,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [7:0]                 in_byte,
  input  logic                       sync,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow
);
  localparam int AW = $clog2(DEPTH);
  logic [2:0] idx, bi;
  logic [7:0] hi;
  logic [15:0] c00, c01, c10, c11;
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic [31:0] mem [DEPTH];
  logic [31:0] word;
  logic push, pop, full, push_ok;
  function automatic logic [7:0] rq(input logic [15:0] c);
    logic signed [15:0] v;
    v = $signed(c) >>> SHIFT;
    if (RELU != 0 && v < 0) v = '0;
    return v > 16'sd127 ? 8'h7f : v < -16'sd128 ? 8'h80 : v[7:0];
  endfunction
  always_comb begin
    bi      = sync ? 3'd0 : idx;
    c11     = {hi, in_byte};
    push    = in_valid && bi == 3'd7;
    pop     = cnt != '0 && out_ready;
    full    = cnt == (AW+1)'(DEPTH);
    push_ok = push && (!full || pop);
    word    = {rq(c11), rq(c10), rq(c01), rq(c00)};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      hi       <= '0;
      c00      <= '0;
      c01      <= '0;
      c10      <= '0;
      wp       <= '0;
      rp       <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      idx <= bi + 3'(in_valid);
      if (in_valid && !bi[0]) hi <= in_byte;
      if (in_valid && bi == 3'd1) c00 <= c11;
      if (in_valid && bi == 3'd3) c01 <= c11;
      if (in_valid && bi == 3'd5) c10 <= c11;
      if (push_ok) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      if (push && full && !pop) overflow <= 1'b1;
      cnt <= cnt + (AW+1)'(push_ok) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem[wp] <= word;
  end
  assign out_valid = cnt != '0;
  assign out_data  = out_valid ? mem[rp] : '0;
  assign level     = cnt;
endmodule

// File: tb/tb_tpu_output_collector.sv
// tb_tpu_output_collector: directed vectors plus random traffic against a queue-based model, three parameter sets
module tb_tpu_output_collector;
  logic clk = 0, rst, in_valid, sync, out_ready;
  logic [7:0] in_byte;
  logic ovld [3];
  logic [31:0] od [3];
  logic [1:0] lvl [3];
  logic ovf [3];
  int total = 0, bad = 0;
  localparam int SH [3] = '{0, 4, 0};
  localparam int RL [3] = '{0, 0, 1};
  always #5 clk = ~clk;
  tpu_output_collector #(.SHIFT(0), .RELU(0), .DEPTH(2)) dut0 (.clk(clk), .rst(rst), .in_valid(in_valid),
    .in_byte(in_byte), .sync(sync), .out_valid(ovld[0]), .out_ready(out_ready), .out_data(od[0]),
    .level(lvl[0]), .overflow(ovf[0]));
  tpu_output_collector #(.SHIFT(4), .RELU(0), .DEPTH(2)) dut1 (.clk(clk), .rst(rst), .in_valid(in_valid),
    .in_byte(in_byte), .sync(sync), .out_valid(ovld[1]), .out_ready(out_ready), .out_data(od[1]),
    .level(lvl[1]), .overflow(ovf[1]));
  tpu_output_collector #(.SHIFT(0), .RELU(1), .DEPTH(2)) dut2 (.clk(clk), .rst(rst), .in_valid(in_valid),
    .in_byte(in_byte), .sync(sync), .out_valid(ovld[2]), .out_ready(out_ready), .out_data(od[2]),
    .level(lvl[2]), .overflow(ovf[2]));
  typedef struct {logic [15:0] c [4];} word_t;
  typedef struct {logic [7:0] b [8]; logic [31:0] e [3];} vec_t;
  word_t mq [$];
  logic [7:0] bq [$];
  bit movf;
  vec_t tbl [4];
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", n, a, e, $time);
    end
  endtask
  function automatic logic [7:0] rq(logic [15:0] c, int sh, int relu);
    int v;
    v = int'($signed(c)) >>> sh;
    if (relu != 0 && v < 0) v = 0;
    if (v > 127) return 8'h7f;
    if (v < -128) return 8'h80;
    return v[7:0];
  endfunction
  function automatic logic [31:0] pack(word_t w, int k);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = rq(w.c[i], SH[k], RL[k]);
    return r;
  endfunction
  task automatic model_edge();
    bit pop;
    word_t w;
    pop = mq.size() > 0 && out_ready;
    if (rst) begin
      mq.delete();
      bq.delete();
      movf = 0;
      return;
    end
    if (sync) bq.delete();
    if (pop) void'(mq.pop_front());
    if (in_valid) begin
      bq.push_back(in_byte);
      if (bq.size() == 8) begin
        for (int i = 0; i < 4; i++) w.c[i] = {bq[2*i], bq[2*i+1]};
        bq.delete();
        if (mq.size() < 2) mq.push_back(w);
        else movf = 1;
      end
    end
  endtask
  task automatic step(bit r, bit v, bit s, logic [7:0] b, bit rd);
    rst = r; in_valid = v; sync = s; in_byte = b; out_ready = rd;
    @(posedge clk);
    model_edge();
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("valid%0d", k), 32'(ovld[k]), 32'(mq.size() > 0));
      chk($sformatf("level%0d", k), 32'(lvl[k]), 32'(mq.size()));
      chk($sformatf("ovf%0d", k), 32'(ovf[k]), 32'(movf));
      if (mq.size() > 0) chk($sformatf("data%0d", k), od[k], pack(mq[0], k));
    end
  endtask
  task automatic feed(int t, bit rd_last);
    for (int i = 0; i < 8; i++) step(0, 1, 0, tbl[t].b[i], i == 7 ? rd_last : 1'b0);
  endtask
  task automatic chk_reset();
    for (int k = 0; k < 3; k++) begin
      chk("rst_valid", 32'(ovld[k]), 0);
      chk("rst_data", od[k], 0);
      chk("rst_level", 32'(lvl[k]), 0);
      chk("rst_ovf", 32'(ovf[k]), 0);
    end
  endtask
  initial begin
    tbl[0] = '{b: '{8'h00, 8'h05, 8'hFF, 8'hFD, 8'h00, 8'h7F, 8'hFF, 8'h80},
               e: '{32'h807FFD05, 32'hF807FF00, 32'h007F0005}};
    tbl[1] = '{b: '{8'h02, 8'h00, 8'hFE, 8'h00, 8'h00, 8'h80, 8'hFF, 8'h7F},
               e: '{32'h807F807F, 32'hF708E020, 32'h007F007F}};
    tbl[2] = '{b: '{8'hFF, 8'hFD, 8'h00, 8'h64, 8'h80, 8'h00, 8'h00, 8'h00},
               e: '{32'h008064FD, 32'h008006FF, 32'h00006400}};
    tbl[3] = '{b: '{8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04},
               e: '{32'h04030201, 32'h00000000, 32'h04030201}};
    step(1, 0, 0, 0, 0);
    chk_reset();
    for (int t = 0; t < 4; t++) begin
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 7; i++) step(0, 1, 0, tbl[t].b[i], 0);
      chk("vec_early_valid", 32'(ovld[0]), 0);
      step(0, 1, 0, tbl[t].b[7], 0);
      chk("vec_valid", 32'(ovld[0]), 1);
      chk("vec_level", 32'(lvl[0]), 1);
      for (int k = 0; k < 3; k++) chk($sformatf("vec%0d_data%0d", t, k), od[k], tbl[t].e[k]);
    end
    step(1, 0, 0, 0, 0);
    feed(0, 0); feed(1, 0); feed(2, 0);
    chk("bp_level", 32'(lvl[0]), 2);
    chk("bp_ovf", 32'(ovf[0]), 1);
    chk("bp_headA", od[0], tbl[0].e[0]);
    step(0, 0, 0, 0, 1);
    chk("bp_headB", od[0], tbl[1].e[0]);
    step(0, 0, 0, 0, 1);
    chk("bp_empty_valid", 32'(ovld[0]), 0);
    chk("bp_empty_level", 32'(lvl[0]), 0);
    step(0, 0, 0, 0, 1);
    chk("bp_no_underflow", 32'(lvl[0]), 0);
    step(1, 0, 0, 0, 0);
    feed(0, 0); feed(1, 0); feed(2, 1);
    chk("pp_level", 32'(lvl[0]), 2);
    chk("pp_ovf", 32'(ovf[0]), 0);
    chk("pp_headB", od[0], tbl[1].e[0]);
    step(0, 0, 0, 0, 1);
    chk("pp_headC", od[0], tbl[2].e[0]);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, tbl[1].b[i], 0);
    step(0, 1, 1, tbl[3].b[0], 0);
    for (int i = 1; i < 8; i++) step(0, 1, 0, tbl[3].b[i], 0);
    step(0, 0, 0, 0, 0);
    chk("sync_level", 32'(lvl[0]), 1);
    chk("sync_data", od[0], 32'h04030201);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, tbl[2].b[i], 0);
    step(1, 1, 1, 8'hAA, 1);
    chk_reset();
    feed(0, 0);
    chk("rst_clean_data", od[0], tbl[0].e[0]);
    chk("rst_clean_level", 32'(lvl[0]), 1);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      bit rd;
      rd = ((i / 150) % 2) ? ($urandom % 8 == 0) : ($urandom % 3 != 0);
      step($urandom % 300 == 0, $urandom % 4 != 0, $urandom % 50 == 0, 8'($urandom), rd);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
